// File: rtl/packet_router.sv
// packet_router: moves RX FIFO words to PC_TX (loopback and SPI replies),
// the SLM_CONFIG SPI master, or a streaming DATA sink. Mode switches are
// deferred until the datapath is idle.
// Optional feature: define ROUTER_SPI_TIMEOUT_EN to abandon an SPI transfer
// after TIMEOUT_CYCLES cycles in CFG_WAIT and reply with an all-zero word.
module packet_router #(
  parameter int DATA_W         = 32,
  parameter int SPI_BYTES      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [1:0]             i_packet_command,
  input  logic                   i_packet_start_decode,
  output logic                   o_rx_fifo_next_word_cmd,
  input  logic [DATA_W-1:0]      i_rx_fifo_output_word,
  input  logic                   i_rx_fifo_is_empty_sig,
  input  logic                   i_serial_is_busy_sig,
  output logic [DATA_W-1:0]      o_data_manager_output_data_word,
  output logic                   o_data_manager_output_next_cmd,
  output logic                   o_enable_spi,
  output logic                   o_start_spi_transfer_cmd,
  output logic [8*SPI_BYTES-1:0] o_spi_tx_word,
  input  logic [8*SPI_BYTES-1:0] i_spi_rx_word,
  input  logic                   i_transaction_complete,
  output logic                   o_data_valid,
  output logic [DATA_W-1:0]      o_data_word,
  input  logic                   i_data_ready,
  output logic [1:0]             o_mode
);

  localparam int SPI_W = 8 * SPI_BYTES;
  localparam logic [1:0] MODE_LB   = 2'd1;
  localparam logic [1:0] MODE_CFG  = 2'd2;
  localparam logic [1:0] MODE_DATA = 2'd3;

  // Reject parameter sets where the SPI word cannot fit in a FIFO word.
  if (SPI_W > DATA_W || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("packet_router: need 8*SPI_BYTES <= DATA_W and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    LB_IDLE, LB_HOLD, CFG_IDLE, CFG_WAIT, CFG_REPLY, DATA_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic              pend_valid_q, pend_valid_d;
  logic [1:0]        pend_mode_q, pend_mode_d;
  logic [DATA_W-1:0] tx_word_q, tx_word_d;
  logic              tx_next_q, tx_next_d;
  logic              spi_en_q, spi_en_d;
  logic              spi_start_q, spi_start_d;
  logic [SPI_W-1:0]  spi_tx_q, spi_tx_d;
  logic [SPI_W-1:0]  spi_rx_q, spi_rx_d;
  logic              data_valid_q, data_valid_d;
  logic [DATA_W-1:0] data_word_q, data_word_d;
  logic              pop_cmd;
  logic              eff_valid, is_idle;
  logic [1:0]        eff_mode;
  logic [DATA_W-1:0] reply_word;
`ifdef ROUTER_SPI_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  // Next-state, mode arbitration and output decode. The FIFO pop is decoded
  // from registered state so the FWFT head word is consumed in the same cycle
  // it is captured, which is what allows one DATA word per cycle.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    tx_word_d    = tx_word_q;
    tx_next_d    = 1'b0;
    spi_start_d  = 1'b0;
    spi_tx_d     = spi_tx_q;
    spi_rx_d     = spi_rx_q;
    data_valid_d = data_valid_q;
    data_word_d  = data_word_q;
    pop_cmd      = 1'b0;
`ifdef ROUTER_SPI_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif

    reply_word = {DATA_W{1'b1}};
    reply_word[DATA_W-1 -: SPI_W] = spi_rx_q;
`ifdef ROUTER_SPI_TIMEOUT_EN
    if (err_q) reply_word = '0;
`endif

    eff_valid = pend_valid_q;
    eff_mode  = pend_mode_q;
    if (i_packet_start_decode && (i_packet_command != 2'd0)) begin
      eff_valid = 1'b1;
      eff_mode  = i_packet_command;
    end
    pend_valid_d = eff_valid;
    pend_mode_d  = eff_mode;

    is_idle = (state_q == LB_IDLE) || (state_q == CFG_IDLE) ||
              ((state_q == DATA_IDLE) && !data_valid_q);

    if (is_idle && eff_valid) begin
      pend_valid_d = 1'b0;
      case (eff_mode)
        MODE_CFG:  begin mode_d = MODE_CFG;  state_d = CFG_IDLE;  end
        MODE_DATA: begin mode_d = MODE_DATA; state_d = DATA_IDLE; end
        default:   begin mode_d = MODE_LB;   state_d = LB_IDLE;   end
      endcase
    end else begin
      case (state_q)
        LB_IDLE: begin
          if (!i_rx_fifo_is_empty_sig && !i_serial_is_busy_sig) begin
            pop_cmd   = 1'b1;
            tx_word_d = i_rx_fifo_output_word;
            tx_next_d = 1'b1;
            state_d   = LB_HOLD;
          end
        end
        LB_HOLD: state_d = LB_IDLE;
        CFG_IDLE: begin
          if (!i_rx_fifo_is_empty_sig) begin
            pop_cmd     = 1'b1;
            spi_tx_d    = i_rx_fifo_output_word[DATA_W-1 -: SPI_W];
            spi_start_d = 1'b1;
            state_d     = CFG_WAIT;
`ifdef ROUTER_SPI_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
        CFG_WAIT: begin
          if (i_transaction_complete) begin
            spi_rx_d = i_spi_rx_word;
            state_d  = CFG_REPLY;
`ifdef ROUTER_SPI_TIMEOUT_EN
            err_d    = 1'b0;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            spi_rx_d = '0;
            err_d    = 1'b1;
            state_d  = CFG_REPLY;
          end else begin
            cnt_d    = cnt_q + CNT_W'(1);
`endif
          end
        end
        CFG_REPLY: begin
          if (!i_serial_is_busy_sig) begin
            tx_word_d = reply_word;
            tx_next_d = 1'b1;
            state_d   = CFG_IDLE;
          end
        end
        DATA_IDLE: begin
          if (!i_rx_fifo_is_empty_sig && (!data_valid_q || i_data_ready)) begin
            pop_cmd      = 1'b1;
            data_word_d  = i_rx_fifo_output_word;
            data_valid_d = 1'b1;
          end else if (i_data_ready) begin
            data_valid_d = 1'b0;
          end
        end
        default: state_d = LB_IDLE;
      endcase
    end

    spi_en_d = (state_d == CFG_IDLE) || (state_d == CFG_WAIT) ||
               (state_d == CFG_REPLY);

    if (i_reset) pop_cmd = 1'b0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= LB_IDLE;
      mode_q       <= MODE_LB;
      pend_valid_q <= 1'b0;
      pend_mode_q  <= 2'd0;
      tx_word_q    <= '0;
      tx_next_q    <= 1'b0;
      spi_en_q     <= 1'b0;
      spi_start_q  <= 1'b0;
      spi_tx_q     <= '0;
      spi_rx_q     <= '0;
      data_valid_q <= 1'b0;
      data_word_q  <= '0;
`ifdef ROUTER_SPI_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      pend_valid_q <= pend_valid_d;
      pend_mode_q  <= pend_mode_d;
      tx_word_q    <= tx_word_d;
      tx_next_q    <= tx_next_d;
      spi_en_q     <= spi_en_d;
      spi_start_q  <= spi_start_d;
      spi_tx_q     <= spi_tx_d;
      spi_rx_q     <= spi_rx_d;
      data_valid_q <= data_valid_d;
      data_word_q  <= data_word_d;
`ifdef ROUTER_SPI_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign o_rx_fifo_next_word_cmd         = pop_cmd;
  assign o_data_manager_output_data_word = tx_word_q;
  assign o_data_manager_output_next_cmd  = tx_next_q;
  assign o_enable_spi                    = spi_en_q;
  assign o_start_spi_transfer_cmd        = spi_start_q;
  assign o_spi_tx_word                   = spi_tx_q;
  assign o_data_valid                    = data_valid_q;
  assign o_data_word                     = data_word_q;
  assign o_mode                          = mode_q;

endmodule

// File: tb/tb_packet_router.sv
// tb_packet_router: directed self-checking bench for packet_router.
// Define ROUTER_SPI_TIMEOUT_EN to also exercise the SPI timeout reply.
module tb_packet_router;

  logic        clock = 1'b0;
  logic        i_reset;
  logic [1:0]  i_packet_command;
  logic        i_packet_start_decode;
  logic        o_rx_fifo_next_word_cmd;
  logic [31:0] i_rx_fifo_output_word;
  logic        i_rx_fifo_is_empty_sig;
  logic        i_serial_is_busy_sig;
  logic [31:0] o_data_manager_output_data_word;
  logic        o_data_manager_output_next_cmd;
  logic        o_enable_spi;
  logic        o_start_spi_transfer_cmd;
  logic [15:0] o_spi_tx_word;
  logic [15:0] i_spi_rx_word;
  logic        i_transaction_complete;
  logic        o_data_valid;
  logic [31:0] o_data_word;
  logic        i_data_ready;
  logic [1:0]  o_mode;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] tx_log[$];
  logic [31:0] sink_log[$];
  int          pop_cycles[$];
  int          pop_count = 0;
  int          cycle_count = 0;
  logic        pop_seen = 1'b0;

  always #5 clock = ~clock;

  packet_router #(.DATA_W(32), .SPI_BYTES(2), .TIMEOUT_CYCLES(16)) dut (
    .i_clock                         (clock),
    .i_reset                         (i_reset),
    .i_packet_command                (i_packet_command),
    .i_packet_start_decode           (i_packet_start_decode),
    .o_rx_fifo_next_word_cmd         (o_rx_fifo_next_word_cmd),
    .i_rx_fifo_output_word           (i_rx_fifo_output_word),
    .i_rx_fifo_is_empty_sig          (i_rx_fifo_is_empty_sig),
    .i_serial_is_busy_sig            (i_serial_is_busy_sig),
    .o_data_manager_output_data_word (o_data_manager_output_data_word),
    .o_data_manager_output_next_cmd  (o_data_manager_output_next_cmd),
    .o_enable_spi                    (o_enable_spi),
    .o_start_spi_transfer_cmd        (o_start_spi_transfer_cmd),
    .o_spi_tx_word                   (o_spi_tx_word),
    .i_spi_rx_word                   (i_spi_rx_word),
    .i_transaction_complete          (i_transaction_complete),
    .o_data_valid                    (o_data_valid),
    .o_data_word                     (o_data_word),
    .i_data_ready                    (i_data_ready),
    .o_mode                          (o_mode)
  );

  // Present the FWFT FIFO head and empty flag from the model queue.
  task automatic refreshFifo();
    i_rx_fifo_is_empty_sig = (fifo_q.size() == 0);
    i_rx_fifo_output_word  = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
  endtask

  task automatic pushWord(input logic [31:0] w);
    fifo_q.push_back(w);
    refreshFifo();
  endtask

  // Compare one observed value with its expected value and count it.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance n clock edges and settle 2 time units past the last edge.
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Issue a one-cycle decode strobe carrying the given command.
  task automatic applyStimulus(input logic [1:0] cmd);
    i_packet_start_decode = 1'b1;
    i_packet_command      = cmd;
    waitCycles(1);
    i_packet_start_decode = 1'b0;
    i_packet_command      = 2'd0;
  endtask

  // Observe handshakes mid-cycle, away from the active edge.
  always @(negedge clock) begin
    cycle_count++;
    pop_seen = o_rx_fifo_next_word_cmd;
    if (o_rx_fifo_next_word_cmd) begin
      pop_count++;
      pop_cycles.push_back(cycle_count);
    end
    if (o_data_manager_output_next_cmd) tx_log.push_back(o_data_manager_output_data_word);
    if (o_data_valid && i_data_ready) sink_log.push_back(o_data_word);
  end

  // The FIFO advances on the edge that sampled the pop.
  always @(posedge clock) begin
    logic [31:0] discard;
    #1;
    if (pop_seen && fifo_q.size() > 0) discard = fifo_q.pop_front();
    refreshFifo();
  end

  logic [31:0] data_words [4] = '{32'h0A0A0001, 32'h0A0A0002, 32'h0A0A0003, 32'h0A0A0004};
  logic        ready_seq  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic        exp_valid  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] exp_data   [7] = '{32'h0A0A0001, 32'h0A0A0001, 32'h0A0A0001,
                                  32'h0A0A0002, 32'h0A0A0003, 32'h0A0A0004, 32'h0A0A0004};

  initial begin
    i_reset                = 1'b1;
    i_packet_command       = 2'd0;
    i_packet_start_decode  = 1'b0;
    i_serial_is_busy_sig   = 1'b0;
    i_spi_rx_word          = 16'h0;
    i_transaction_complete = 1'b0;
    i_data_ready           = 1'b0;
    refreshFifo();
    pushWord(32'hDEADBEEF);

    // Reset state, with a word waiting that must not be popped yet.
    waitCycles(3);
    checkOutput("rst_mode", o_mode, 2'd1);
    checkOutput("rst_pop", o_rx_fifo_next_word_cmd, 1'b0);
    checkOutput("rst_next", o_data_manager_output_next_cmd, 1'b0);
    checkOutput("rst_word", o_data_manager_output_data_word, 32'h0);
    checkOutput("rst_en", o_enable_spi, 1'b0);
    checkOutput("rst_valid", o_data_valid, 1'b0);

    // Loopback single word.
    i_reset = 1'b0;
    waitCycles(1);
    checkOutput("lb_next", o_data_manager_output_next_cmd, 1'b1);
    checkOutput("lb_word", o_data_manager_output_data_word, 32'hDEADBEEF);
    checkOutput("lb_pops", pop_count, 1);
    waitCycles(1);
    checkOutput("lb_next_drop", o_data_manager_output_next_cmd, 1'b0);

    // Loopback under back-pressure.
    i_serial_is_busy_sig = 1'b1;
    pushWord(32'h11111111);
    pushWord(32'h22222222);
    waitCycles(10);
    checkOutput("lb_busy_pops", pop_count, 1);
    i_serial_is_busy_sig = 1'b0;
    waitCycles(6);
    checkOutput("lb_pops2", pop_count, 3);
    checkOutput("lb_gap", pop_cycles[2] - pop_cycles[1], 2);
    checkOutput("lb_tx1", tx_log[1], 32'h11111111);
    checkOutput("lb_tx2", tx_log[2], 32'h22222222);

    // CONFIG transaction with deferred switch back to loopback.
    applyStimulus(2'd2);
    checkOutput("cfg_mode", o_mode, 2'd2);
    checkOutput("cfg_en", o_enable_spi, 1'b1);
    pushWord(32'hA5120000);
    waitCycles(1);
    checkOutput("cfg_start", o_start_spi_transfer_cmd, 1'b1);
    checkOutput("cfg_tx", o_spi_tx_word, 16'hA512);
    checkOutput("cfg_pops", pop_count, 4);
    waitCycles(1);
    checkOutput("cfg_start_drop", o_start_spi_transfer_cmd, 1'b0);
    applyStimulus(2'd1);
    checkOutput("cfg_mode_hold", o_mode, 2'd2);
    pushWord(32'h33334444);
    i_serial_is_busy_sig = 1'b1;
    waitCycles(3);
    checkOutput("cfg_wait_pops", pop_count, 4);
    i_spi_rx_word          = 16'h00C3;
    i_transaction_complete = 1'b1;
    waitCycles(1);
    i_transaction_complete = 1'b0;
    waitCycles(3);
    checkOutput("cfg_busy_replies", tx_log.size(), 3);
    i_serial_is_busy_sig = 1'b0;
    waitCycles(1);
    checkOutput("cfg_reply_next", o_data_manager_output_next_cmd, 1'b1);
    checkOutput("cfg_reply_word", o_data_manager_output_data_word, 32'h00C3FFFF);
    checkOutput("cfg_reply_mode", o_mode, 2'd2);
    waitCycles(1);
    checkOutput("sw_mode", o_mode, 2'd1);
    checkOutput("sw_en", o_enable_spi, 1'b0);
    checkOutput("sw_pops", pop_count, 4);
    waitCycles(1);
    checkOutput("sw_lb_word", o_data_manager_output_data_word, 32'h33334444);
    checkOutput("sw_lb_start", o_start_spi_transfer_cmd, 1'b0);
    checkOutput("sw_lb_pops", pop_count, 5);
    waitCycles(2);

    // DATA streaming with stalls.
    applyStimulus(2'd3);
    checkOutput("data_mode", o_mode, 2'd3);
    for (int i = 0; i < 4; i++) pushWord(data_words[i]);
    for (int i = 0; i < 7; i++) begin
      i_data_ready = ready_seq[i];
      waitCycles(1);
      checkOutput($sformatf("data_valid_%0d", i), o_data_valid, exp_valid[i]);
      checkOutput($sformatf("data_word_%0d", i), o_data_word, exp_data[i]);
    end
    checkOutput("sink_count", sink_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < sink_log.size())
        checkOutput($sformatf("sink_word_%0d", i), sink_log[i], data_words[i]);
    checkOutput("data_pops", pop_count, 9);
    i_data_ready = 1'b0;

    // Reset in the middle of an SPI wait, with a pending mode.
    applyStimulus(2'd2);
    checkOutput("rcfg_mode", o_mode, 2'd2);
    pushWord(32'hBEEF0000);
    waitCycles(1);
    checkOutput("rcfg_start", o_start_spi_transfer_cmd, 1'b1);
    waitCycles(2);
    applyStimulus(2'd3);
    i_reset = 1'b1;
    waitCycles(1);
    checkOutput("rcfg_rst_mode", o_mode, 2'd1);
    checkOutput("rcfg_rst_en", o_enable_spi, 1'b0);
    checkOutput("rcfg_rst_tx", o_spi_tx_word, 16'h0);
    checkOutput("rcfg_rst_word", o_data_manager_output_data_word, 32'h0);
    i_reset                = 1'b0;
    i_spi_rx_word          = 16'h1234;
    i_transaction_complete = 1'b1;
    waitCycles(1);
    i_transaction_complete = 1'b0;
    waitCycles(3);
    checkOutput("late_mode", o_mode, 2'd1);
    checkOutput("late_en", o_enable_spi, 1'b0);
    checkOutput("late_replies", tx_log.size(), 5);

`ifdef ROUTER_SPI_TIMEOUT_EN
    // SPI timeout produces the zero error reply.
    applyStimulus(2'd2);
    pushWord(32'h55550000);
    waitCycles(1);
    checkOutput("to_start", o_start_spi_transfer_cmd, 1'b1);
    waitCycles(16);
    checkOutput("to_early", o_data_manager_output_next_cmd, 1'b0);
    waitCycles(1);
    checkOutput("to_next", o_data_manager_output_next_cmd, 1'b1);
    checkOutput("to_word", o_data_manager_output_data_word, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
